// File: rtl/cursor_nav_ctrl.sv
// Board cursor controller: synchronizes and debounces five buttons, runs an
// auto-repeat FSM per direction and maintains cursor and selection registers.
module cursor_nav_ctrl #(
    parameter int unsigned BOARD_DIM    = 8,
    parameter int unsigned LOC_W        = 6,
    parameter int unsigned DB_CYCLES    = 500000,
    parameter int unsigned REPEAT_DELAY = 25000000,
    parameter int unsigned REPEAT_RATE  = 5000000,
    parameter int unsigned WRAP         = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_btn_up,
    input  logic             in_btn_down,
    input  logic             in_btn_left,
    input  logic             in_btn_right,
    input  logic             in_selected,
    output logic [LOC_W-1:0] location,
    output logic [LOC_W-1:0] sel_loc,
    output logic             sel_valid,
    output logic             sel_pulse,
    output logic             move_pulse
);

    localparam int unsigned N_IN    = 5;
    localparam int unsigned N_DIR   = 4;
    localparam int unsigned DIR_UP  = 0;
    localparam int unsigned DIR_DN  = 1;
    localparam int unsigned DIR_LT  = 2;
    localparam int unsigned DIR_RT  = 3;
    localparam int unsigned IDX_SEL = 4;
    localparam int unsigned RC_W    = (BOARD_DIM > 1) ? $clog2(BOARD_DIM) : 1;
    localparam int unsigned DB_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_e;

    logic [N_IN-1:0]  sync1_q, sync1_d, sync2_q, sync2_d, db_q, db_d;
    logic [DB_W-1:0]  db_cnt_q [N_IN];
    logic [DB_W-1:0]  db_cnt_d [N_IN];
    rpt_state_e       st_q [N_DIR];
    rpt_state_e       st_d [N_DIR];
    logic [RPT_W-1:0] rpt_cnt_q [N_DIR];
    logic [RPT_W-1:0] rpt_cnt_d [N_DIR];
    logic [N_DIR-1:0] req_c;
    logic             sel_prev_q, sel_prev_d, sel_rise_c;
    logic [RC_W-1:0]  row_q, row_d, col_q, col_d;
    logic [LOC_W-1:0] location_q, location_d, sel_loc_q, sel_loc_d;
    logic             sel_valid_q, sel_valid_d, sel_pulse_q, sel_pulse_d;
    logic             move_pulse_q, move_pulse_d;

    // Two-flop synchronizers and per-input debounce counters
    always_comb begin
        sync1_d = {in_selected, in_btn_right, in_btn_left, in_btn_down, in_btn_up};
        sync2_d = sync1_q;
        db_d    = db_q;
        for (int i = 0; i < int'(N_IN); i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DB_W'(DB_CYCLES - 1)) begin
                    db_d[i] = ~db_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    // Auto-repeat FSM per direction; a release always wins over a pending request
    always_comb begin
        for (int d = 0; d < int'(N_DIR); d++) begin
            st_d[d]      = st_q[d];
            rpt_cnt_d[d] = rpt_cnt_q[d];
            req_c[d]     = 1'b0;
            case (st_q[d])
                ST_IDLE: begin
                    if (db_q[d]) begin
                        st_d[d]      = ST_DELAY;
                        rpt_cnt_d[d] = '0;
                        req_c[d]     = 1'b1;
                    end
                end
                ST_DELAY: begin
                    if (!db_q[d]) begin
                        st_d[d]      = ST_IDLE;
                        rpt_cnt_d[d] = '0;
                    end else if (rpt_cnt_q[d] == RPT_W'(REPEAT_DELAY - 1)) begin
                        st_d[d]      = ST_REPEAT;
                        rpt_cnt_d[d] = '0;
                        req_c[d]     = 1'b1;
                    end else begin
                        rpt_cnt_d[d] = rpt_cnt_q[d] + RPT_W'(1);
                    end
                end
                ST_REPEAT: begin
                    if (!db_q[d]) begin
                        st_d[d]      = ST_IDLE;
                        rpt_cnt_d[d] = '0;
                    end else if (rpt_cnt_q[d] == RPT_W'(REPEAT_RATE - 1)) begin
                        rpt_cnt_d[d] = '0;
                        req_c[d]     = 1'b1;
                    end else begin
                        rpt_cnt_d[d] = rpt_cnt_q[d] + RPT_W'(1);
                    end
                end
                default: begin
                    st_d[d]      = ST_IDLE;
                    rpt_cnt_d[d] = '0;
                end
            endcase
        end
    end

    // Cursor move (priority up > down > left > right) and selection update
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (req_c[DIR_UP]) begin
            if (row_q != '0)      row_d = row_q - RC_W'(1);
            else if (WRAP != 0)   row_d = RC_W'(BOARD_DIM - 1);
        end else if (req_c[DIR_DN]) begin
            if (row_q != RC_W'(BOARD_DIM - 1)) row_d = row_q + RC_W'(1);
            else if (WRAP != 0)                row_d = '0;
        end else if (req_c[DIR_LT]) begin
            if (col_q != '0)      col_d = col_q - RC_W'(1);
            else if (WRAP != 0)   col_d = RC_W'(BOARD_DIM - 1);
        end else if (req_c[DIR_RT]) begin
            if (col_q != RC_W'(BOARD_DIM - 1)) col_d = col_q + RC_W'(1);
            else if (WRAP != 0)                col_d = '0;
        end
        move_pulse_d = (row_d != row_q) || (col_d != col_q);
        location_d   = LOC_W'(row_d) * LOC_W'(BOARD_DIM) + LOC_W'(col_d);

        sel_prev_d  = db_q[IDX_SEL];
        sel_rise_c  = db_q[IDX_SEL] & ~sel_prev_q;
        sel_loc_d   = sel_loc_q;
        sel_valid_d = sel_valid_q;
        sel_pulse_d = sel_rise_c;
        if (sel_rise_c) begin
            if (!sel_valid_q) begin
                sel_loc_d   = location_q;
                sel_valid_d = 1'b1;
            end else if (location_q == sel_loc_q) begin
                sel_valid_d = 1'b0;
            end else begin
                sel_loc_d = location_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            db_q         <= '0;
            for (int i = 0; i < int'(N_IN); i++) db_cnt_q[i] <= '0;
            for (int d = 0; d < int'(N_DIR); d++) begin
                st_q[d]      <= ST_IDLE;
                rpt_cnt_q[d] <= '0;
            end
            sel_prev_q   <= 1'b0;
            row_q        <= '0;
            col_q        <= '0;
            location_q   <= '0;
            sel_loc_q    <= '0;
            sel_valid_q  <= 1'b0;
            sel_pulse_q  <= 1'b0;
            move_pulse_q <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            db_q         <= db_d;
            for (int i = 0; i < int'(N_IN); i++) db_cnt_q[i] <= db_cnt_d[i];
            for (int d = 0; d < int'(N_DIR); d++) begin
                st_q[d]      <= st_d[d];
                rpt_cnt_q[d] <= rpt_cnt_d[d];
            end
            sel_prev_q   <= sel_prev_d;
            row_q        <= row_d;
            col_q        <= col_d;
            location_q   <= location_d;
            sel_loc_q    <= sel_loc_d;
            sel_valid_q  <= sel_valid_d;
            sel_pulse_q  <= sel_pulse_d;
            move_pulse_q <= move_pulse_d;
        end
    end

    assign location   = location_q;
    assign sel_loc    = sel_loc_q;
    assign sel_valid  = sel_valid_q;
    assign sel_pulse  = sel_pulse_q;
    assign move_pulse = move_pulse_q;

endmodule

// File: tb/tb_cursor_nav_ctrl.sv
// Scoreboard bench for cursor_nav_ctrl: one clamping and one wrapping instance,
// expected pulses queued with their cycle of arrival when buttons are driven.
module tb_cursor_nav_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] btn0 = '0;
    logic [4:0] btn1 = '0;
    logic [5:0] loc0, loc1, sl0, sl1;
    logic       sv0, sv1, sp0, sp1, mp0, mp1;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_err = 0;

    typedef struct {
        int dut;
        int loc;
        int valid;
        int cyc;
    } exp_t;

    exp_t mq[$];
    exp_t sq[$];

    localparam logic [4:0] UP = 5'b00001, DN = 5'b00010, LT = 5'b00100,
                           RT = 5'b01000, SEL = 5'b10000;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cursor_nav_ctrl #(.BOARD_DIM(8), .LOC_W(6), .DB_CYCLES(4), .REPEAT_DELAY(10),
                      .REPEAT_RATE(3), .WRAP(0)) dut0 (
        .clk(clk), .rst(rst),
        .in_btn_up(btn0[0]), .in_btn_down(btn0[1]), .in_btn_left(btn0[2]),
        .in_btn_right(btn0[3]), .in_selected(btn0[4]),
        .location(loc0), .sel_loc(sl0), .sel_valid(sv0),
        .sel_pulse(sp0), .move_pulse(mp0)
    );

    cursor_nav_ctrl #(.BOARD_DIM(8), .LOC_W(6), .DB_CYCLES(4), .REPEAT_DELAY(10),
                      .REPEAT_RATE(3), .WRAP(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_btn_up(btn1[0]), .in_btn_down(btn1[1]), .in_btn_left(btn1[2]),
        .in_btn_right(btn1[3]), .in_selected(btn1[4]),
        .location(loc1), .sel_loc(sl1), .sel_valid(sv1),
        .sel_pulse(sp1), .move_pulse(mp1)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Compare every observed pulse against the head of its queue
    task automatic mon();
        logic [5:0] l, s;
        logic       v, spl, mpl;
        exp_t       e;
        if (rst) return;
        for (int i = 0; i < 2; i++) begin
            l   = (i == 0) ? loc0 : loc1;
            s   = (i == 0) ? sl0  : sl1;
            v   = (i == 0) ? sv0  : sv1;
            spl = (i == 0) ? sp0  : sp1;
            mpl = (i == 0) ? mp0  : mp1;
            if (mpl) begin
                if (mq.size() == 0) begin
                    chk("move_unexpected", 1, 0);
                end else begin
                    e = mq.pop_front();
                    chk("move_dut", i, e.dut);
                    chk("move_loc", int'(l), e.loc);
                    chk("move_cyc", cyc, e.cyc);
                end
            end
            if (spl) begin
                if (sq.size() == 0) begin
                    chk("sel_unexpected", 1, 0);
                end else begin
                    e = sq.pop_front();
                    chk("sel_dut", i, e.dut);
                    chk("sel_valid", int'(v), e.valid);
                    chk("sel_loc", int'(s), e.loc);
                    chk("sel_cyc", cyc, e.cyc);
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
    endtask

    task automatic set_btn(input int d, input logic [4:0] m);
        if (d == 0) btn0 = m;
        else        btn1 = m;
    endtask

    // Hold a button mask for 8 cycles; a pulse is due 7 cycles after the press
    task automatic tap(input int d, input logic [4:0] m, input int mv, input int sv, input int sl);
        int c0;
        tick();
        c0 = cyc;
        set_btn(d, m);
        if (mv >= 0) mq.push_back('{dut: d, loc: mv, valid: 0, cyc: c0 + 7});
        if (sv >= 0) sq.push_back('{dut: d, loc: sl, valid: sv, cyc: c0 + 7});
        repeat (8) tick();
        set_btn(d, '0);
        repeat (20) tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_loc0"}, int'(loc0), 0);
        chk({tag, "_selloc0"}, int'(sl0), 0);
        chk({tag, "_selvalid0"}, int'(sv0), 0);
        chk({tag, "_selpulse0"}, int'(sp0), 0);
        chk({tag, "_movepulse0"}, int'(mp0), 0);
    endtask

    initial begin
        int c0;
        int r0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        chk("rst_loc1", int'(loc1), 0);
        chk("rst_selvalid1", int'(sv1), 0);
        rst = 1'b0;
        repeat (3) tick();

        // Clamping instance: tap, glitch, edge clamp
        tap(0, RT, 1, -1, 0);
        tick();
        btn0 = RT;
        repeat (2) tick();
        btn0 = '0;
        repeat (20) tick();
        chk("glitch_loc", int'(loc0), 1);
        tap(0, LT, 0, -1, 0);
        tap(0, UP, -1, -1, 0);
        chk("clamp_up_loc", int'(loc0), 0);

        // Hold down: press, +10, then every 3 cycles until row 7
        tick();
        c0 = cyc;
        btn0 = DN;
        mq.push_back('{dut: 0, loc: 8,  valid: 0, cyc: c0 + 7});
        mq.push_back('{dut: 0, loc: 16, valid: 0, cyc: c0 + 17});
        mq.push_back('{dut: 0, loc: 24, valid: 0, cyc: c0 + 20});
        mq.push_back('{dut: 0, loc: 32, valid: 0, cyc: c0 + 23});
        mq.push_back('{dut: 0, loc: 40, valid: 0, cyc: c0 + 26});
        mq.push_back('{dut: 0, loc: 48, valid: 0, cyc: c0 + 29});
        mq.push_back('{dut: 0, loc: 56, valid: 0, cyc: c0 + 32});
        repeat (28) tick();
        btn0 = '0;
        repeat (20) tick();
        chk("hold_end_loc", int'(loc0), 56);

        // Walk to 27, then up+left together
        tap(0, UP, 48, -1, 0);
        tap(0, UP, 40, -1, 0);
        tap(0, UP, 32, -1, 0);
        tap(0, UP, 24, -1, 0);
        tap(0, RT, 25, -1, 0);
        tap(0, RT, 26, -1, 0);
        tap(0, RT, 27, -1, 0);
        tap(0, UP | LT, 19, -1, 0);
        chk("prio_loc", int'(loc0), 19);

        // Selection sequence around square 12
        tap(0, UP, 11, -1, 0);
        tap(0, RT, 12, -1, 0);
        tap(0, SEL, -1, 1, 12);
        tap(0, SEL, -1, 0, 12);
        tap(0, SEL, -1, 1, 12);
        tap(0, RT, 13, -1, 0);
        tap(0, SEL, -1, 1, 13);
        tap(0, RT | SEL, 14, 0, 13);
        chk("sel_final_valid", int'(sv0), 0);
        chk("sel_final_loc", int'(sl0), 13);

        // Wrapping instance
        tap(1, DN, 8, -1, 0);
        tap(1, LT, 15, -1, 0);
        tap(1, RT, 8, -1, 0);
        tap(1, UP, 0, -1, 0);
        tap(1, LT, 7, -1, 0);
        tap(1, LT, 6, -1, 0);
        tap(1, LT, 5, -1, 0);
        tap(1, LT, 4, -1, 0);
        tap(1, LT, 3, -1, 0);
        tap(1, UP, 59, -1, 0);
        tap(1, DN, 3, -1, 0);
        chk("wrap_final_loc", int'(loc1), 3);

        // Reset while holding right in REPEAT at location 5
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        repeat (3) tick();
        tap(0, RT, 1, -1, 0);
        tap(0, RT, 2, -1, 0);
        tap(0, RT, 3, -1, 0);
        tick();
        c0 = cyc;
        btn0 = RT;
        mq.push_back('{dut: 0, loc: 4, valid: 0, cyc: c0 + 7});
        mq.push_back('{dut: 0, loc: 5, valid: 0, cyc: c0 + 17});
        repeat (18) tick();
        chk("pre_rst_loc", int'(loc0), 5);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midhold_rst");
        tick();
        r0 = cyc;
        rst = 1'b0;
        mq.push_back('{dut: 0, loc: 1, valid: 0, cyc: r0 + 7});
        repeat (10) tick();
        btn0 = '0;
        repeat (20) tick();
        chk("post_rst_loc", int'(loc0), 1);

        chk("move_queue_left", mq.size(), 0);
        chk("sel_queue_left", sq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/cursor_nav_ctrl.md
CURSOR_NAV_CTRL -- requirements
Module: cursor_nav_ctrl

Interface
REQ-001 SHALL have parameter BOARD_DIM, default 8: squares per board side (2..16).
REQ-002 SHALL have parameter LOC_W, default 6: location width, equal to ceil(log2(BOARD_DIM*BOARD_DIM)).
REQ-003 SHALL have parameter DB_CYCLES, default 500000: consecutive cycles a raw input must differ from its debounced value before the debounced value changes.
REQ-004 SHALL have parameter REPEAT_DELAY, default 25000000: hold cycles after a press before auto-repeat starts.
REQ-005 SHALL have parameter REPEAT_RATE, default 5000000: cycles between auto-repeat moves.
REQ-006 SHALL have parameter WRAP, default 0: 0 = clamp at board edge, 1 = wrap to the opposite edge.
REQ-007 SHALL have port clk, input, 1: single clock; all state on its rising edge.
REQ-008 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-009 SHALL have ports in_btn_up, in_btn_down, in_btn_left, in_btn_right, in_selected, input, 1 each: raw, asynchronous, active-high buttons.
REQ-010 SHALL have port location, output, LOC_W: cursor square, encoded row*BOARD_DIM+col, row 0 at top, col 0 at left.
REQ-011 SHALL have port sel_loc, output, LOC_W: selected square.
REQ-012 SHALL have port sel_valid, output, 1: high while a square is selected.
REQ-013 SHALL have port sel_pulse, output, 1: one-cycle strobe on every change to sel_loc or sel_valid.
REQ-014 SHALL have port move_pulse, output, 1: one-cycle strobe on every change to location.

Function
REQ-015 SHALL pass each raw input through a two-flop synchronizer before debouncing.
REQ-016 SHALL debounce each input with its own counter; the counter clears whenever the synchronized value equals the debounced value; the debounced value toggles when the counter reaches DB_CYCLES.
REQ-017 SHALL run one 3-state FSM per direction button: IDLE, DELAY, REPEAT.
REQ-018 Each FSM SHALL go IDLE->DELAY on a debounced rising edge and issue one move request.
REQ-019 Each FSM SHALL go DELAY->REPEAT after REPEAT_DELAY held cycles and issue a request.
REQ-020 In REPEAT, each FSM SHALL issue a request every REPEAT_RATE cycles.
REQ-021 Each FSM SHALL return to IDLE from any state on a debounced release, with no request in that cycle.
REQ-022 SHALL apply at most one move per cycle; simultaneous requests resolve with priority up > down > left > right, and losing requests are dropped, not queued.
REQ-023 SHALL register location one cycle after the request; move_pulse is asserted in the same cycle location updates.
REQ-024 Moves: up = row-1, down = row+1, left = col-1, right = col+1.
REQ-025 With WRAP=0, a move past an edge SHALL leave location unchanged and SHALL NOT assert move_pulse.
REQ-026 With WRAP=1, a move past an edge SHALL wrap within the same row or column: row 0 up goes to row BOARD_DIM-1, col BOARD_DIM-1 right goes to col 0.
REQ-027 The debounced in_selected rising edge SHALL act on the current location (the value before any same-cycle move) as follows:
  - if sel_valid=0: set sel_loc=location and sel_valid=1;
  - if sel_valid=1 and location==sel_loc: clear sel_valid and hold sel_loc;
  - otherwise: set sel_loc=location.
  - Each case SHALL assert sel_pulse for exactly one cycle.
REQ-028 A select and a move in the same cycle SHALL both take effect.
REQ-029 in_selected SHALL NOT auto-repeat.
REQ-030 Location arithmetic SHALL use row/col fields of width ceil(log2(BOARD_DIM)); location SHALL never exceed BOARD_DIM*BOARD_DIM-1.

Reset
REQ-031 On rst high, asynchronously: location=0, sel_loc=0, sel_valid=0, sel_pulse=0, move_pulse=0, all FSMs in IDLE, debounced values 0, all counters 0.
REQ-032 Reset asserted mid-hold SHALL abort the hold; after release, a button still held SHALL count as a new press only after DB_CYCLES stable cycles.

Verification (BOARD_DIM=8, DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3)
REQ-033 Tap right for 8 cycles from reset -> location 0->1, one move_pulse; a 2-cycle glitch -> no move.
REQ-034 WRAP=0: press up at location 0 -> location stays 0, no move_pulse; WRAP=1: press left at 8 -> 15; press up at 3 -> 59.
REQ-035 Hold down from 0 for 40 cycles after debounce -> one move at press, next at +10 cycles, then every 3 cycles; location 8,16,24,...
REQ-036 Up and left pressed in the same cycle at 27 -> location 19 only; left dropped.
REQ-037 Select at 12 -> sel_valid=1, sel_loc=12; select again at 12 -> sel_valid=0; select at 12 then move to 13 and select -> sel_loc=13; sel_pulse once each time.
REQ-038 Assert rst while holding right in REPEAT at location 5 -> all outputs 0 immediately; hold continues -> next move only after 4 stable cycles plus registration.
